// File: rtl/mc_block_predictor_pkg.sv
// mc_block_predictor_pkg: shared geometry constants and FSM state type for the block predictor.
package mc_pkg;
  localparam int BLK = 4;
  localparam int MV_W = 3;
  localparam int WIN = BLK + 2**MV_W - 1;
  localparam int ADDR_W = $clog2(WIN*WIN);
  localparam int CNT_W = $clog2(BLK);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLK-1);
  localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(WIN*WIN-1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_MV, EMIT} state_t;
endpackage

// File: rtl/mc_block_predictor_if.sv
// mc_block_predictor_if: window stream, motion vector and predicted-pixel stream bundle.
// flush exists only when MC_REUSE_EN is defined.
interface mc_block_predictor_if;
  import mc_pkg::*;
  logic [7:0] s_data;
  logic s_valid, s_ready;
  logic [MV_W-1:0] mv_x, mv_y;
  logic mv_valid, mv_ready;
  logic [7:0] p_data;
  logic p_valid, p_ready, p_last, busy;
`ifdef MC_REUSE_EN
  logic flush;
`endif
  modport master (
`ifdef MC_REUSE_EN
    output flush,
`endif
    output s_data, s_valid, mv_x, mv_y, mv_valid, p_ready,
    input s_ready, mv_ready, p_data, p_valid, p_last, busy
  );
  modport slave (
`ifdef MC_REUSE_EN
    input flush,
`endif
    input s_data, s_valid, mv_x, mv_y, mv_valid, p_ready,
    output s_ready, mv_ready, p_data, p_valid, p_last, busy
  );
endinterface

// File: rtl/mc_window_buf.sv
// mc_window_buf: WIN*WIN byte window store, one sync write port and one async read port.
module mc_window_buf import mc_pkg::*; (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  logic [7:0] r_mem [WIN*WIN];
  always_ff @(posedge clk)
    if (wr_en) r_mem[wr_addr] <= wr_data;
  assign rd_data = r_mem[rd_addr];
endmodule

// File: rtl/mc_block_predictor.sv
// mc_block_predictor: buffers a search window and emits the BLK x BLK block at each motion vector.
// MC_REUSE_EN keeps the window for further vectors and adds a flush input.
module mc_block_predictor import mc_pkg::*; (
  input logic clk,
  input logic rst_n,
  mc_block_predictor_if.slave bus
);
  state_t r_state, w_state_n;
  logic [ADDR_W-1:0] r_wr_idx, w_wr_addr, w_rd_addr;
  logic [MV_W-1:0] r_mvx, r_mvy;
  logic [CNT_W-1:0] r_row, r_col, w_row_n, w_col_n;
  logic [MV_W:0] w_ax, w_ay;
  logic [7:0] w_rd_data, r_p_data;
  logic r_p_valid, r_p_last, w_last_n;
  logic w_s_hs, w_mv_hs, w_p_hs, w_flush, w_reuse;
`ifdef MC_REUSE_EN
  assign w_flush = bus.flush;
  assign w_reuse = 1'b1;
`else
  assign w_flush = 1'b0;
  assign w_reuse = 1'b0;
`endif
  assign bus.s_ready = (r_state == IDLE) || (r_state == LOAD);
  assign bus.mv_ready = (r_state == WAIT_MV) && !w_flush;
  assign bus.busy = r_state != IDLE;
  assign bus.p_data = r_p_data;
  assign bus.p_valid = r_p_valid;
  assign bus.p_last = r_p_last;
  assign w_s_hs = bus.s_valid && bus.s_ready;
  assign w_mv_hs = bus.mv_valid && bus.mv_ready;
  assign w_p_hs = r_p_valid && bus.p_ready && (r_state == EMIT);
  assign w_wr_addr = (r_state == IDLE) ? '0 : r_wr_idx;
  // Outside EMIT the read port looks ahead at pixel 0 of the incoming vector.
  assign w_col_n = (r_state != EMIT || r_col == CNT_MAX) ? '0 : r_col + 1'b1;
  assign w_row_n = (r_state != EMIT) ? '0 : r_row + CNT_W'(r_col == CNT_MAX);
  assign w_last_n = (w_row_n == CNT_MAX) && (w_col_n == CNT_MAX);
  assign w_ax = (MV_W+1)'(r_state == EMIT ? r_mvx : bus.mv_x) + (MV_W+1)'(w_col_n);
  assign w_ay = (MV_W+1)'(r_state == EMIT ? r_mvy : bus.mv_y) + (MV_W+1)'(w_row_n);
  assign w_rd_addr = ADDR_W'(w_ay) * ADDR_W'(WIN) + ADDR_W'(w_ax);
  mc_window_buf u_buf (
    .clk     (clk),
    .wr_en   (w_s_hs),
    .wr_addr (w_wr_addr),
    .wr_data (bus.s_data),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_n;
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = w_s_hs ? LOAD : IDLE;
      LOAD:    w_state_n = (w_s_hs && r_wr_idx == WIN_LAST) ? WAIT_MV : LOAD;
      WAIT_MV: w_state_n = w_flush ? IDLE : w_mv_hs ? EMIT : WAIT_MV;
      EMIT:    w_state_n = (w_p_hs && r_p_last) ? (w_reuse ? WAIT_MV : IDLE) : EMIT;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_idx <= '0;
      r_mvx <= '0;
      r_mvy <= '0;
      r_row <= '0;
      r_col <= '0;
      r_p_data <= '0;
      r_p_valid <= 1'b0;
      r_p_last <= 1'b0;
    end else begin
      if (w_s_hs) r_wr_idx <= (w_wr_addr == WIN_LAST) ? '0 : w_wr_addr + 1'b1;
      if (w_mv_hs) begin
        r_mvx <= bus.mv_x;
        r_mvy <= bus.mv_y;
        r_row <= '0;
        r_col <= '0;
        r_p_data <= w_rd_data;
        r_p_valid <= 1'b1;
        r_p_last <= 1'b0;
      end else if (w_p_hs) begin
        r_row <= w_row_n;
        r_col <= w_col_n;
        r_p_data <= r_p_last ? r_p_data : w_rd_data;
        r_p_valid <= !r_p_last;
        r_p_last <= !r_p_last && w_last_n;
      end
    end
endmodule

// File: tb/tb_mc_block_predictor.sv
// tb_mc_block_predictor: directed checks of window load, block emission, stalls and reset abort.
module tb_mc_block_predictor;
  import mc_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int n_pass = 0;
  int n_tot = 0;
  mc_block_predictor_if bus();
  mc_block_predictor dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic load_window(input int n, input bit inv, input bit chk_mv);
    for (int i = 0; i < n; i++) begin
      bus.s_data = 8'(inv ? 255 - i : i);
      bus.s_valid = 1'b1;
      if (chk_mv) begin
        n_tot++;
        if (bus.mv_ready !== 1'b0) $display("FAIL mv_ready_in_load byte %0d: got %b want 0", i, bus.mv_ready);
        else n_pass++;
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic run_block(input string name, input logic [MV_W-1:0] mx, input logic [MV_W-1:0] my,
                           input logic [7:0] exp_d [16], input logic [3:0] pat);
    int k = 0;
    int cyc = 0;
    bit rdy;
    bus.mv_x = mx;
    bus.mv_y = my;
    bus.mv_valid = 1'b1;
    while (bus.mv_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    bus.mv_valid = 1'b0;
    n_tot++;
    if (cyc >= 50 || bus.p_valid !== 1'b1) $display("FAIL %s mv_accept: p_valid=%b wait=%0d want p_valid=1", name, bus.p_valid, cyc);
    else n_pass++;
    cyc = 0;
    while (k < 16 && cyc < 200) begin
      rdy = pat[cyc % 4];
      n_tot++;
      if (bus.p_valid !== 1'b1) $display("FAIL %s p_valid pix%0d: got %b want 1", name, k, bus.p_valid);
      else begin
        n_pass++;
        n_tot++;
        if (bus.p_data !== exp_d[k]) $display("FAIL %s p_data pix%0d: got %0d want %0d", name, k, bus.p_data, exp_d[k]);
        else n_pass++;
        n_tot++;
        if (bus.p_last !== (k == 15)) $display("FAIL %s p_last pix%0d: got %b want %b", name, k, bus.p_last, k == 15);
        else n_pass++;
        if (rdy) k++;
      end
      bus.p_ready = rdy;
      @(negedge clk);
      cyc++;
    end
    bus.p_ready = 1'b1;
    n_tot++;
    if (k != 16 || bus.p_valid !== 1'b0) $display("FAIL %s done: handshakes=%0d p_valid=%b want 16 and 0", name, k, bus.p_valid);
    else n_pass++;
  endtask

  task automatic end_block(input string name);
`ifdef MC_REUSE_EN
    n_tot++;
    if (bus.busy !== 1'b1 || bus.mv_ready !== 1'b1) $display("FAIL %s reuse_wait: busy=%b mv_ready=%b want 1 1", name, bus.busy, bus.mv_ready);
    else n_pass++;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
`endif
    n_tot++;
    if (bus.busy !== 1'b0 || bus.s_ready !== 1'b1) $display("FAIL %s idle: busy=%b s_ready=%b want 0 1", name, bus.busy, bus.s_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_tot++;
    if ({bus.s_ready, bus.mv_ready, bus.p_valid, bus.p_last, bus.busy} !== 5'b10000)
      $display("FAIL reset flags: s_ready,mv_ready,p_valid,p_last,busy=%b want 10000",
               {bus.s_ready, bus.mv_ready, bus.p_valid, bus.p_last, bus.busy});
    else n_pass++;
    n_tot++;
    if (bus.p_data !== 8'd0) $display("FAIL reset p_data: got %0d want 0", bus.p_data);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mv00();
    logic [7:0] e [16] = '{0,1,2,3,11,12,13,14,22,23,24,25,33,34,35,36};
    load_window(121, 1'b0, 1'b0);
    n_tot++;
    if (bus.s_ready !== 1'b0 || bus.mv_ready !== 1'b1) $display("FAIL load_done: s_ready=%b mv_ready=%b want 0 1", bus.s_ready, bus.mv_ready);
    else n_pass++;
    run_block("mv00", 3'd0, 3'd0, e, 4'b1111);
    end_block("mv00");
  endtask

  task automatic test_mv77();
    logic [7:0] e [16] = '{84,85,86,87,95,96,97,98,106,107,108,109,117,118,119,120};
    load_window(121, 1'b0, 1'b0);
    run_block("mv77", 3'd7, 3'd7, e, 4'b1111);
    end_block("mv77");
  endtask

  task automatic test_stall();
    logic [7:0] e [16] = '{14,15,16,17,25,26,27,28,36,37,38,39,47,48,49,50};
    load_window(121, 1'b0, 1'b0);
    run_block("stall31", 3'd3, 3'd1, e, 4'b1001);
    end_block("stall31");
  endtask

  task automatic test_reset_midload();
    logic [7:0] e [16] = '{255,254,253,252,244,243,242,241,233,232,231,230,222,221,220,219};
    load_window(60, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_tot++;
    if (bus.busy !== 1'b0 || bus.s_ready !== 1'b1) $display("FAIL midload_reset: busy=%b s_ready=%b want 0 1", bus.busy, bus.s_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_window(121, 1'b1, 1'b0);
    run_block("reload", 3'd0, 3'd0, e, 4'b1111);
    end_block("reload");
  endtask

  task automatic test_mv_early();
    logic [7:0] e [16] = '{23,24,25,26,34,35,36,37,45,46,47,48,56,57,58,59};
    bus.mv_x = 3'd1;
    bus.mv_y = 3'd2;
    bus.mv_valid = 1'b1;
    load_window(121, 1'b0, 1'b1);
    n_tot++;
    if (bus.mv_ready !== 1'b1) $display("FAIL mv_early first_wait: mv_ready=%b want 1", bus.mv_ready);
    else n_pass++;
    run_block("mv_early", 3'd1, 3'd2, e, 4'b1111);
    end_block("mv_early");
  endtask

`ifdef MC_REUSE_EN
  task automatic test_reuse();
    logic [7:0] e0 [16] = '{0,1,2,3,11,12,13,14,22,23,24,25,33,34,35,36};
    logic [7:0] e1 [16] = '{57,58,59,60,68,69,70,71,79,80,81,82,90,91,92,93};
    load_window(121, 1'b0, 1'b0);
    run_block("reuse0", 3'd0, 3'd0, e0, 4'b1111);
    n_tot++;
    if (bus.mv_ready !== 1'b1) $display("FAIL reuse back_to_wait: mv_ready=%b want 1", bus.mv_ready);
    else n_pass++;
    run_block("reuse1", 3'd2, 3'd5, e1, 4'b1111);
    end_block("reuse1");
  endtask
`endif

  initial begin
    bus.s_data = '0;
    bus.s_valid = 1'b0;
    bus.mv_x = '0;
    bus.mv_y = '0;
    bus.mv_valid = 1'b0;
    bus.p_ready = 1'b1;
`ifdef MC_REUSE_EN
    bus.flush = 1'b0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_mv00();
    test_mv77();
    test_stall();
    test_reset_midload();
    test_mv_early();
`ifdef MC_REUSE_EN
    test_reuse();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mc_block_predictor.md
Name: mc_block_predictor

Overview:
- Motion-compensation end of the motion-estimation path: the estimator consumes an 8-bit pixel stream and produces (motion_vec_x, motion_vec_y, min_sae). This block consumes the same pixel stream format plus a motion vector, and reconstructs the predicted block.
- Buffers one search window delivered raster-order on an 8-bit byte stream.
- On each accepted motion vector, emits the BLK x BLK predicted block, raster-order, on a valid/ready byte stream.
- Sits beside the estimator in the user project; the vector is driven from the estimator outputs or from the IO pins.

Parameters:
- BLK, 4, block edge in pixels.
- MV_W, 3, motion vector component width; unsigned offset 0..2**MV_W-1.
- WIN, BLK+2**MV_W-1 (=11), window edge in pixels; derived, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s_data  input  8  window pixel byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  block accepts s_data.
- mv_x  input  MV_W  horizontal offset into window.
- mv_y  input  MV_W  vertical offset into window.
- mv_valid  input  1  vector valid.
- mv_ready  output  1  block accepts vector.
- p_data  output  8  predicted pixel.
- p_valid  output  1  p_data valid.
- p_ready  input  1  downstream accepts p_data.
- p_last  output  1  final pixel of block (with p_valid).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; s_ready=1, mv_ready=0, p_valid=0, p_last=0, p_data=0, busy=0; write/read counters=0; window contents undefined (not cleared).
- States and transitions:
  - IDLE: s_ready=1. First s_valid&&s_ready stores byte at window index 0 and goes to LOAD.
  - LOAD: s_ready=1. Each handshake writes index wr_idx (row-major, row*WIN+col) and increments it. The handshake writing index WIN*WIN-1 goes to WAIT_MV; s_ready=0 from the next cycle.
  - WAIT_MV: mv_ready=1, s_ready=0. On mv_valid, latch mv_x/mv_y, clear row/col counters and go to EMIT.
  - EMIT: p_valid rises the cycle after the mv handshake (latency 1, registered output).
    - Pixel k (r=k/BLK, c=k%BLK) = window[(mv_y+r)*WIN + mv_x + c].
    - Advance only on p_valid&&p_ready. p_data and p_last hold stable while p_valid&&!p_ready.
    - p_last=1 on pixel BLK*BLK-1. Its handshake drops p_valid next cycle and returns to IDLE.
- A mv_valid arriving outside WAIT_MV is not accepted (mv_ready=0); the source holds it.
- s_valid while s_ready=0 is ignored; no data loss is tracked.
- Extreme vectors mv=(2**MV_W-1, 2**MV_W-1) address the last window row/column exactly. No clamping is needed; the address never exceeds WIN*WIN-1.
- Address arithmetic: row/col sums are MV_W+1 bits; the linear address is 7 bits for defaults.
- Reset mid-LOAD or mid-EMIT aborts immediately. The partial window is discarded; the next load restarts at index 0.
- Full throughput: one byte per cycle in LOAD, one pixel per cycle in EMIT with p_ready held high.

Optional Feature:
- MC_REUSE_EN.
- Defined: after the p_last handshake, go to WAIT_MV instead of IDLE and keep the window, so multiple vectors can be applied to one window. Adds input flush (1 bit): when high in WAIT_MV, go to IDLE next cycle. flush is ignored in other states.
- Undefined: one vector per window load; no flush port.

Decomposition:
- Package mc_pkg holds:
  - BLK, MV_W, WIN constants.
  - Address width localparam ($clog2(WIN*WIN)).
  - State enum: IDLE, LOAD, WAIT_MV, EMIT.
- Sub-module mc_window_buf: WIN*WIN x 8 storage with one write port (wr_en, wr_addr, wr_data) and one read port (rd_addr, rd_data).
  - Asynchronous read, so the top registers p_data.
- Top holds the FSM, counters and address generation.

Test Plan:
- Load window with byte i = i; mv=(0,0), p_ready=1 -> p_data 0,1,2,3,11,12,13,14,22,23,24,25,33,34,35,36; p_last only on 36; back to IDLE.
- Same window, mv=(7,7) -> 84,85,86,87,95,96,97,98,106..109,117..120; no out-of-range read.
- mv=(3,1), p_ready toggled 1-0-0-1 pattern -> sequence 14,15,16,17,25,... unchanged; p_data held stable during stalls; 16 handshakes total.
- Assert rst_n low after 60 load bytes, release, load 121 fresh bytes (value 255-i), mv=(0,0) -> 255,254,253,252,244,...; no stale data.
- mv_valid held high throughout LOAD -> mv_ready=0 until byte 120 accepted; vector accepted first cycle of WAIT_MV; first p_valid one cycle later.
- MC_REUSE_EN: two vectors (0,0) then (2,5) without reload -> both blocks correct; flush -> busy=0 next cycle, s_ready=1.
